mipi_tx_line_sched: RTL

MIPI_TX_LINE_SCHED -- requirements
Module: mipi_tx_line_sched

---
 rtl/mipi_tx_pkg.sv | 35 +++
 rtl/mipi_tx_timing_cnt.sv | 60 ++++++
 rtl/mipi_tx_line_sched.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mipi_tx_pkg.sv
// Shared definitions for the MIPI TX line scheduler.
// Contents: lane geometry, the fixed SYNC and TRAIL words, the scheduler
// state type and a per-lane bit-reversal helper.
package mipi_tx_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 16;

  localparam logic [63:0] SYNC_WORD  = 64'h001D_001D_001D_001D;
  localparam logic [63:0] TRAIL_WORD = 64'h00CA_00BA_00CA_00BA;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PREP    = 3'd1,
    SYNC    = 3'd2,
    HDR     = 3'd3,
    PAYLOAD = 3'd4,
    TRAIL   = 3'd5,
    HBLANK  = 3'd6,
    VBLANK  = 3'd7
  } tx_state_e;

  // Mirror bit order inside every 16-bit lane field (bit0 <-> bit15).
  function automatic logic [63:0] lane_bitrev(input logic [63:0] w);
    logic [63:0] r;
    r = 64'h0;
    for (int l = 0; l < LANES; l++) begin
      for (int b = 0; b < LANE_W; b++) begin
        r[l*LANE_W + b] = w[l*LANE_W + LANE_W - 1 - b];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mipi_tx_timing_cnt.sv
// Horizontal / vertical position counters for the MIPI TX line scheduler.
// Ports:
//   clkx2        byte clock
//   rstn         asynchronous active-low reset
//   i_run        count when high; counters are held at zero when low
//   o_hcnt       position within the line, 0 .. HTOTAL_W-1
//   o_vcnt       line within the frame, 0 .. VTOTAL-1
//   o_line_end   last cycle of a line
//   o_frame_end  last cycle of a frame
module mipi_tx_timing_cnt
  import mipi_tx_pkg::*;
#(
  parameter int HTOTAL_W = 550,
  parameter int VTOTAL   = 112,
  localparam int HW      = $clog2(HTOTAL_W),
  localparam int VW      = $clog2(VTOTAL)
) (
  input  logic          clkx2,
  input  logic          rstn,
  input  logic          i_run,
  output logic [HW-1:0] o_hcnt,
  output logic [VW-1:0] o_vcnt,
  output logic          o_line_end,
  output logic          o_frame_end
);

  localparam logic [HW-1:0] H_LAST = HW'(HTOTAL_W - 1);
  localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);

  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic          w_line_end;
  logic          w_frame_end;

  assign w_line_end  = (r_hcnt == H_LAST);
  assign w_frame_end = w_line_end && (r_vcnt == V_LAST);

  // Line / frame position counters; both wrap to zero at the end of their span.
  always_ff @(posedge clkx2 or negedge rstn) begin
    if (!rstn) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (!i_run) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_line_end) begin
      r_hcnt <= '0;
      r_vcnt <= w_frame_end ? '0 : r_vcnt + VW'(1);
    end else begin
      r_hcnt <= r_hcnt + HW'(1);
      r_vcnt <= r_vcnt;
    end
  end

  assign o_hcnt      = r_hcnt;
  assign o_vcnt      = r_vcnt;
  assign o_line_end  = w_line_end;
  assign o_frame_end = w_frame_end;

endmodule

// File: rtl/mipi_tx_line_sched.sv
// MIPI TX line scheduler: sequences SYNC / header / payload / trailer words
// for each active line and blanking for the rest of the frame.
// Every output is a flop. tx_data, hs_en, line_start and frame_done are a
// registered decode of the state register, so they trail the state by one
// cycle. pix_ready and busy are registered from the next state, so they line
// up with the state register itself. A word accepted on a pix_ready cycle
// therefore appears on tx_data in the following cycle.
// Ports:
//   clkx2, rstn      byte clock, asynchronous active-low reset
//   start            single-cycle frame request (one extra request is queued while busy)
//   continuous       restart frames automatically
//   pix_data/valid   four 16-bit lane words in, lane3 in [63:48]
//   pix_ready        word accepted this cycle (PAYLOAD only)
//   tx_data, hs_en   DPHY data_in0..3 and hs_clk_en/hs_data_en
//   line_start       pulse with the PREP cycle of every active line
//   frame_done       pulse on the last VBLANK cycle
//   underrun         sticky: a payload slot had no valid word
//   busy             any state other than IDLE
// Build option: MIPI_TX_BITREV_EN bit-reverses each lane field of tx_data.
module mipi_tx_line_sched
  import mipi_tx_pkg::*;
#(
  parameter int          HACTIVE_W = 480,
  parameter int          HTOTAL_W  = 550,
  parameter int          VACTIVE   = 100,
  parameter int          VTOTAL    = 112,
  parameter logic [63:0] HDR_WORD  = 64'h00B8_0060_0006_0054
) (
  input  logic        clkx2,
  input  logic        rstn,
  input  logic        start,
  input  logic        continuous,
  input  logic [63:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [63:0] tx_data,
  output logic        hs_en,
  output logic        line_start,
  output logic        frame_done,
  output logic        underrun,
  output logic        busy
);

  localparam int HW = $clog2(HTOTAL_W);
  localparam int VW = $clog2(VTOTAL);

  // hcnt at the last PAYLOAD and last TRAIL cycle (PREP sits at hcnt 0).
  localparam logic [HW-1:0] H_PAY_LAST = HW'(HACTIVE_W + 2);
  localparam logic [HW-1:0] H_TRL_LAST = HW'(HACTIVE_W + 4);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(VACTIVE - 1);

  tx_state_e     r_state;
  tx_state_e     w_state_nxt;
  logic          r_pend;
  logic [HW-1:0] w_hcnt;
  logic [VW-1:0] w_vcnt;
  logic          w_line_end;
  logic          w_frame_end;
  logic          w_run;
  logic          w_restart;
  logic [63:0]   w_tx_word;

  assign w_run     = (r_state != IDLE);
  // A start landing in the frame-end cycle itself also counts as a restart.
  assign w_restart = continuous | r_pend | start;

  mipi_tx_timing_cnt #(
    .HTOTAL_W (HTOTAL_W),
    .VTOTAL   (VTOTAL)
  ) u_timing (
    .clkx2       (clkx2),
    .rstn        (rstn),
    .i_run       (w_run),
    .o_hcnt      (w_hcnt),
    .o_vcnt      (w_vcnt),
    .o_line_end  (w_line_end),
    .o_frame_end (w_frame_end)
  );

  // Next-state selection driven by the position counters.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = PREP; else w_state_nxt = IDLE;
      PREP:    w_state_nxt = SYNC;
      SYNC:    w_state_nxt = HDR;
      HDR:     w_state_nxt = PAYLOAD;
      PAYLOAD: if (w_hcnt == H_PAY_LAST) w_state_nxt = TRAIL; else w_state_nxt = PAYLOAD;
      TRAIL:   if (w_hcnt == H_TRL_LAST) w_state_nxt = HBLANK; else w_state_nxt = TRAIL;
      HBLANK: begin
        if (w_line_end) begin
          if (w_vcnt == V_ACT_LAST) w_state_nxt = VBLANK; else w_state_nxt = PREP;
        end else begin
          w_state_nxt = HBLANK;
        end
      end
      VBLANK: begin
        if (w_frame_end) begin
          if (w_restart) w_state_nxt = PREP; else w_state_nxt = IDLE;
        end else begin
          w_state_nxt = VBLANK;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Word to launch for the current state; a missing pixel word sends zeros.
  always_comb begin
    w_tx_word = 64'h0;
    case (r_state)
      SYNC:    w_tx_word = SYNC_WORD;
      HDR:     w_tx_word = HDR_WORD;
      PAYLOAD: if (pix_valid) w_tx_word = pix_data; else w_tx_word = 64'h0;
      TRAIL:   w_tx_word = TRAIL_WORD;
      default: w_tx_word = 64'h0;
    endcase
  end

  // State register, pending start, sticky underrun and all registered outputs.
  always_ff @(posedge clkx2 or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_pend     <= 1'b0;
      tx_data    <= 64'h0;
      hs_en      <= 1'b0;
      line_start <= 1'b0;
      frame_done <= 1'b0;
      pix_ready  <= 1'b0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
`ifdef MIPI_TX_BITREV_EN
      tx_data <= lane_bitrev(w_tx_word);
`else
      tx_data <= w_tx_word;
`endif
      hs_en      <= (r_state inside {PREP, SYNC, HDR, PAYLOAD, TRAIL});
      line_start <= (r_state == PREP);
      frame_done <= (r_state == VBLANK) && w_frame_end;
      pix_ready  <= (w_state_nxt == PAYLOAD);
      busy       <= (w_state_nxt != IDLE);

      if (r_state == IDLE && start) underrun <= 1'b0;
      else if (r_state == PAYLOAD && !pix_valid) underrun <= 1'b1;
      else underrun <= underrun;

      // Only one queued request; it is used up at the next frame boundary.
      if (r_state == IDLE) r_pend <= 1'b0;
      else if (r_state == VBLANK && w_frame_end) r_pend <= 1'b0;
      else if (start) r_pend <= 1'b1;
      else r_pend <= r_pend;
    end
  end

endmodule
